// File: rtl/cim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cim_pkg
//  Description : Shared constants, FSM state type and bit-count helper for the
//                CIM input sequencer and read word-line driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package cim_pkg;

  localparam int CH_NUM   = 8;
  localparam int BITS_MAX = 24;
  localparam int XIN_W    = CH_NUM * BITS_MAX;
  localparam int SEL_W    = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Final bit-step index of a sequence: 11 for 12-bit inputs, 23 for 24-bit.
  function automatic logic [SEL_W-1:0] last_idx(input logic inwidth);
    return inwidth ? SEL_W'(BITS_MAX - 1) : SEL_W'((BITS_MAX / 2) - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/done_dly.sv
`default_nettype none
// ============================================================================
//  Module      : done_dly
//  Description : 1-bit delay line of configurable depth with async reset.
//                Carries several in-flight last-bit markers at once so that
//                back-to-back sequences each get their own completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module done_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_any
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Zero depth: straight wire, nothing ever pending.
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q      = i_d;
      assign o_any    = 1'b0;
    end else if (DEPTH == 1) begin : g_one
      logic r_sr;
      // Single-stage delay.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sr <= 1'b0;
        else     r_sr <= i_d;
      end
      assign o_q   = r_sr;
      assign o_any = r_sr;
    end else begin : g_multi
      logic [DEPTH-1:0] r_sr;
      // Shift the marker one stage per cycle toward the output.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sr <= '0;
        else     r_sr <= {r_sr[DEPTH-2:0], i_d};
      end
      assign o_q   = r_sr[DEPTH-1];
      assign o_any = |r_sr;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rwl_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rwl_seq_ctrl
//  Description : Bit-serial input sequencer feeding the read word-line driver.
//                Captures a 192-bit vector plus bank/width on start, then steps
//                the bit-select index over 12 or 24 cycles, flagging first/last
//                steps and a delayed completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module rwl_seq_ctrl
  import cim_pkg::*;
#(
  parameter int DONE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic              cima_in,
  input  logic              inwidth_in,
  input  logic [XIN_W-1:0]  xin_in,
  output logic              cima,
  output logic              inwidth,
  output logic [SEL_W-1:0]  sel,
  output logic [XIN_W-1:0]  xin,
  output logic              rd_en,
  output logic              bit_first,
  output logic              bit_last,
  output logic              busy,
  output logic              done
);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [XIN_W-1:0]   r_xin;
  logic               r_cima;
  logic               r_inwidth;
  logic               w_run;
  logic               w_last;
  logic               w_ready;
  logic               w_load;
  logic               w_clear;
  logic               w_done_q;
  logic               w_done_any;

  assign w_run  = (r_state == ST_RUN);
  // The counter stops at N-1, so an equality compare is all that is needed.
  assign w_last = (r_sel == last_idx(r_inwidth));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus load/clear strobes; a start is only taken when ready.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_ready = 1'b1;
          if (start) begin
            w_load = 1'b1;
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture and bit-step counter; xin returns to 0 so idle word lines are inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= '0;
      r_xin     <= '0;
      r_cima    <= 1'b0;
      r_inwidth <= 1'b0;
    end else if (w_load) begin
      r_sel     <= '0;
      r_xin     <= xin_in;
      r_cima    <= cima_in;
      r_inwidth <= inwidth_in;
    end else if (w_clear) begin
      r_sel     <= '0;
      r_xin     <= '0;
    end else if (w_run) begin
      r_sel     <= r_sel + SEL_W'(1);
    end
  end

  done_dly #(
    .DEPTH (DONE_LAT)
  ) u_done_dly (
    .clk   (clk),
    .rst   (rst),
    .i_d   (bit_last),
    .o_q   (w_done_q),
    .o_any (w_done_any)
  );

  assign ready     = w_ready;
  assign rd_en     = w_run;
  assign bit_first = w_run & (r_sel == '0);
  assign bit_last  = w_run & w_last;
  assign sel       = r_sel;
  assign xin       = r_xin;
  assign cima      = r_cima;
  assign inwidth   = r_inwidth;
  assign done      = w_done_q;
  assign busy      = w_run | w_done_any;

endmodule
`default_nettype wire

// File: tb/tb_rwl_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rwl_seq_ctrl
//  Description : Scoreboard bench for rwl_seq_ctrl. Two instances share the
//                stimulus: DONE_LAT=2 (fully checked) and DONE_LAT=0 (done and
//                busy timing). Directed vectors push expected steps/pulses into
//                queues; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rwl_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cima_in;
  logic         inwidth_in;
  logic [191:0] xin_in;

  logic         d2_ready, d2_cima, d2_inwidth, d2_rd_en, d2_bit_first, d2_bit_last, d2_busy, d2_done;
  logic [5:0]   d2_sel;
  logic [191:0] d2_xin;
  logic         d0_ready, d0_cima, d0_inwidth, d0_rd_en, d0_bit_first, d0_bit_last, d0_busy, d0_done;
  logic [5:0]   d0_sel;
  logic [191:0] d0_xin;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    int           cyc;
    logic [5:0]   sel;
    logic         f;
    logic         l;
    logic         c;
    logic         w;
    logic [191:0] x;
  } exp_t;

  exp_t exp_q[$];
  int   done2_q[$];
  int   done0_q[$];
  exp_t mon_e;
  int   mon_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rwl_seq_ctrl #(.DONE_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .ready(d2_ready),
    .cima_in(cima_in), .inwidth_in(inwidth_in), .xin_in(xin_in),
    .cima(d2_cima), .inwidth(d2_inwidth), .sel(d2_sel), .xin(d2_xin),
    .rd_en(d2_rd_en), .bit_first(d2_bit_first), .bit_last(d2_bit_last),
    .busy(d2_busy), .done(d2_done)
  );

  rwl_seq_ctrl #(.DONE_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .ready(d0_ready),
    .cima_in(cima_in), .inwidth_in(inwidth_in), .xin_in(xin_in),
    .cima(d0_cima), .inwidth(d0_inwidth), .sel(d0_sel), .xin(d0_xin),
    .rd_en(d0_rd_en), .bit_first(d0_bit_first), .bit_last(d0_bit_last),
    .busy(d0_busy), .done(d0_done)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected steps for a sequence whose start is sampled at edge t.
  function automatic void push_seq(input int t, input bit w, input bit c, input logic [191:0] x);
    int   n;
    exp_t e;
    n = w ? 24 : 12;
    for (int k = 0; k < n; k++) begin
      e.cyc = t + k;
      e.sel = 6'(k);
      e.f   = (k == 0);
      e.l   = (k == n - 1);
      e.c   = c;
      e.w   = w;
      e.x   = x;
      exp_q.push_back(e);
    end
    done2_q.push_back(t + n - 1 + 2);
    done0_q.push_back(t + n - 1);
  endfunction

  // Called at a negedge; returns at the negedge where sel=0 is visible.
  task automatic launch(input bit w, input bit c, input logic [191:0] x);
    start      = 1'b1;
    inwidth_in = w;
    cima_in    = c;
    xin_in     = x;
    push_seq(cyc + 1, w, c, x);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every live step and every done pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (d2_rd_en) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL step_unexpected: got rd_en=1 sel=%0d at cyc %0d want no step", d2_sel, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc !== mon_e.cyc || d2_sel !== mon_e.sel || d2_bit_first !== mon_e.f ||
              d2_bit_last !== mon_e.l || d2_cima !== mon_e.c || d2_inwidth !== mon_e.w ||
              d2_xin !== mon_e.x) begin
            nerr++;
            $display("FAIL step: got cyc=%0d sel=%0d first=%b last=%b cima=%b w=%b xin=%h want cyc=%0d sel=%0d first=%b last=%b cima=%b w=%b xin=%h",
                     cyc, d2_sel, d2_bit_first, d2_bit_last, d2_cima, d2_inwidth, d2_xin,
                     mon_e.cyc, mon_e.sel, mon_e.f, mon_e.l, mon_e.c, mon_e.w, mon_e.x);
          end
        end
      end
      if (d2_done) begin
        nvec++;
        if (done2_q.size() == 0) begin
          nerr++;
          $display("FAIL done2_unexpected: got done at cyc %0d want none", cyc);
        end else begin
          mon_c = done2_q.pop_front();
          if (cyc != mon_c) begin
            nerr++;
            $display("FAIL done2_time: got cyc %0d want cyc %0d", cyc, mon_c);
          end
        end
      end
      if (d0_done) begin
        nvec++;
        if (done0_q.size() == 0) begin
          nerr++;
          $display("FAIL done0_unexpected: got done at cyc %0d want none", cyc);
        end else begin
          mon_c = done0_q.pop_front();
          if (cyc != mon_c) begin
            nerr++;
            $display("FAIL done0_time: got cyc %0d want cyc %0d", cyc, mon_c);
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cima_in    = 1'b0;
    inwidth_in = 1'b0;
    xin_in     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 192'(d2_ready), 192'd1);
    chk("rst_rd_en", 192'(d2_rd_en), 192'd0);
    chk("rst_sel",   192'(d2_sel),   192'd0);
    chk("rst_xin",   d2_xin,         192'd0);
    chk("rst_cima",  192'(d2_cima),  192'd0);
    chk("rst_inwidth", 192'(d2_inwidth), 192'd0);
    chk("rst_first", 192'(d2_bit_first), 192'd0);
    chk("rst_last",  192'(d2_bit_last),  192'd0);
    chk("rst_done",  192'(d2_done), 192'd0);
    chk("rst_busy",  192'(d2_busy), 192'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 192'(d2_ready), 192'd1);
    chk("idle_xin",   d2_xin,         192'd0);

    // 12-bit run, bank 1
    launch(1'b0, 1'b1, {24{8'hA5}});
    repeat (12) @(negedge clk);
    chk("r12_end_xin",   d2_xin,           192'd0);
    chk("r12_end_ready", 192'(d2_ready),   192'd1);
    chk("r12_end_rd_en", 192'(d2_rd_en),   192'd0);
    chk("r12_end_sel",   192'(d2_sel),     192'd0);
    chk("r12_keep_cima", 192'(d2_cima),    192'd1);
    chk("r12_keep_w",    192'(d2_inwidth), 192'd0);
    chk("r12_busy2",     192'(d2_busy),    192'd1);
    chk("r12_busy0",     192'(d0_busy),    192'd0);
    repeat (4) @(negedge clk);
    chk("r12_busy2_idle", 192'(d2_busy), 192'd0);

    // 24-bit back-to-back with start held high
    start      = 1'b1;
    inwidth_in = 1'b1;
    cima_in    = 1'b0;
    xin_in     = {8{24'h123456}};
    push_seq(cyc + 1, 1'b1, 1'b0, {8{24'h123456}});
    push_seq(cyc + 25, 1'b1, 1'b0, {12{16'hBEEF}});
    @(negedge clk);
    xin_in = {12{16'hBEEF}};
    repeat (24) @(negedge clk);
    start = 1'b0;
    repeat (28) @(negedge clk);

    // Start during a run is ignored
    launch(1'b0, 1'b0, {6{32'h0F1E2D3C}});
    repeat (5) @(negedge clk);
    start      = 1'b1;
    cima_in    = 1'b1;
    inwidth_in = 1'b1;
    xin_in     = {4{48'h0123456789AB}};
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ign_idle_rd_en", 192'(d2_rd_en), 192'd0);

    // Mid-run asynchronous reset
    launch(1'b1, 1'b1, {3{64'hFEDCBA9876543210}});
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    done2_q.delete();
    done0_q.delete();
    #1;
    chk("arst_rd_en", 192'(d2_rd_en), 192'd0);
    chk("arst_sel",   192'(d2_sel),   192'd0);
    chk("arst_xin",   d2_xin,         192'd0);
    chk("arst_busy",  192'(d2_busy),  192'd0);
    chk("arst_ready", 192'(d2_ready), 192'd1);
    chk("arst_cima",  192'(d2_cima),  192'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    launch(1'b0, 1'b0, {24{8'h3C}});
    repeat (20) @(negedge clk);

    // Every expected step and pulse must have been seen
    chk("left_steps", 192'(exp_q.size()),   192'd0);
    chk("left_done2", 192'(done2_q.size()), 192'd0);
    chk("left_done0", 192'(done0_q.size()), 192'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
